// File: rtl/video_timing_meter.sv
// video_timing_meter: passive observer of a ce_pix/sync/blank raster that
// measures line and frame geometry and reports when it is stable.
module video_timing_meter #(
    parameter int HW        = 12,
    parameter int VW        = 11,
    parameter int H_TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic          h_sync,
    input  logic          v_sync,
    input  logic          h_blank,
    input  logic          v_blank,
    output logic [HW-1:0] h_total,
    output logic [HW-1:0] h_active,
    output logic [HW-1:0] h_sync_w,
    output logic [VW-1:0] v_total,
    output logic [VW-1:0] v_active,
    output logic [VW-1:0] v_sync_w,
    output logic          frame_stb,
    output logic          locked
);
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [HW-1:0] H_TO = HW'(H_TIMEOUT);

    // Saturating increments: counters stick at all-ones instead of wrapping.
    function automatic logic [HW-1:0] hinc(input logic [HW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [VW-1:0] vinc(input logic [VW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t        state_q, state_d;
    logic          hs_q, hs_d, vs_q, vs_d;
    logic [HW-1:0] pix_cnt_q, pix_cnt_d;
    logic [HW-1:0] act_cnt_q, act_cnt_d;
    logic [HW-1:0] hsw_cnt_q, hsw_cnt_d;
    logic [HW-1:0] line_total_q, line_total_d;
    logic [HW-1:0] line_hsw_q, line_hsw_d;
    logic [HW-1:0] frame_hact_q, frame_hact_d;
    logic [VW-1:0] vact_cnt_q, vact_cnt_d;
    logic [VW-1:0] line_cnt_q, line_cnt_d;
    logic [VW-1:0] vsw_cnt_q, vsw_cnt_d;
    logic [HW-1:0] h_total_q, h_total_d, h_active_q, h_active_d, h_sync_w_q, h_sync_w_d;
    logic [VW-1:0] v_total_q, v_total_d, v_active_q, v_active_d, v_sync_w_q, v_sync_w_d;
    logic          frame_stb_q, frame_stb_d;

    logic          hs_rise, vs_rise, pix_act, timeout, same;
    logic          clr_frame, latch;
    logic [HW-1:0] hact_c;
    logic [VW-1:0] vact_c;

    assign hs_rise = ce_pix & h_sync & ~hs_q;
    assign vs_rise = ce_pix & v_sync & ~vs_q;
    assign pix_act = ~h_blank & ~v_blank;
    assign timeout = (pix_cnt_q >= H_TO);

    // Frame totals with the line finishing this cycle already folded in; a
    // line that ends on a v_sync rise still belongs to the old frame.
    assign hact_c = (hs_rise && (act_cnt_q > frame_hact_q)) ? act_cnt_q : frame_hact_q;
    assign vact_c = (hs_rise && (act_cnt_q != '0)) ? vinc(vact_cnt_q) : vact_cnt_q;

    // The line started by a coincident h_sync rise is not part of the
    // finishing frame, so v_total and v_sync_w use the pre-increment counts.
    assign same = (line_total_d == h_total_q) && (line_hsw_d == h_sync_w_q) &&
                  (hact_c == h_active_q) && (line_cnt_q == v_total_q) &&
                  (vact_c == v_active_q) && (vsw_cnt_q == v_sync_w_q);

    // Per-line pixel counters and line commit on each h_sync rise.
    always_comb begin
        hs_d         = hs_q;
        vs_d         = vs_q;
        pix_cnt_d    = pix_cnt_q;
        act_cnt_d    = act_cnt_q;
        hsw_cnt_d    = hsw_cnt_q;
        line_total_d = line_total_q;
        line_hsw_d   = line_hsw_q;
        if (ce_pix) begin
            hs_d = h_sync;
            vs_d = v_sync;
            if (hs_rise) begin
                line_total_d = pix_cnt_q;
                line_hsw_d   = hsw_cnt_q;
                // current pixel is pixel 0 of the new line (h_sync is high)
                pix_cnt_d    = {{(HW-1){1'b0}}, 1'b1};
                act_cnt_d    = {{(HW-1){1'b0}}, pix_act};
                hsw_cnt_d    = {{(HW-1){1'b0}}, 1'b1};
            end else begin
                pix_cnt_d = hinc(pix_cnt_q);
                if (pix_act) act_cnt_d = hinc(act_cnt_q);
                if (h_sync)  hsw_cnt_d = hinc(hsw_cnt_q);
            end
        end
    end

    // FSM: arm on v_sync rise, latch/compare each frame, drop out on timeout.
    always_comb begin
        state_d   = state_q;
        clr_frame = 1'b0;
        latch     = 1'b0;
        if (timeout) begin
            state_d = SEARCH;
        end else if (vs_rise) begin
            clr_frame = 1'b1;
            if (state_q == SEARCH) begin
                state_d = MEASURE;
            end else begin
                latch   = 1'b1;
                state_d = same ? LOCKED : MEASURE;
            end
        end
    end

    // Frame accumulators and the registered output set.
    always_comb begin
        frame_hact_d = hact_c;
        vact_cnt_d   = vact_c;
        line_cnt_d   = hs_rise ? vinc(line_cnt_q) : line_cnt_q;
        vsw_cnt_d    = (hs_rise && v_sync) ? vinc(vsw_cnt_q) : vsw_cnt_q;
        if (clr_frame) begin
            frame_hact_d = '0;
            vact_cnt_d   = '0;
            // a coincident h_sync rise opens line 1 of the new frame, inside v_sync
            line_cnt_d   = {{(VW-1){1'b0}}, hs_rise};
            vsw_cnt_d    = {{(VW-1){1'b0}}, hs_rise};
        end
        h_total_d   = h_total_q;
        h_active_d  = h_active_q;
        h_sync_w_d  = h_sync_w_q;
        v_total_d   = v_total_q;
        v_active_d  = v_active_q;
        v_sync_w_d  = v_sync_w_q;
        frame_stb_d = latch;
        if (latch) begin
            h_total_d  = line_total_d;
            h_active_d = hact_c;
            h_sync_w_d = line_hsw_d;
            v_total_d  = line_cnt_q;
            v_active_d = vact_c;
            v_sync_w_d = vsw_cnt_q;
        end
    end

    // State register; reset discards any partial measurement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SEARCH;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            pix_cnt_q    <= '0;
            act_cnt_q    <= '0;
            hsw_cnt_q    <= '0;
            line_total_q <= '0;
            line_hsw_q   <= '0;
            frame_hact_q <= '0;
            vact_cnt_q   <= '0;
            line_cnt_q   <= '0;
            vsw_cnt_q    <= '0;
            h_total_q    <= '0;
            h_active_q   <= '0;
            h_sync_w_q   <= '0;
            v_total_q    <= '0;
            v_active_q   <= '0;
            v_sync_w_q   <= '0;
            frame_stb_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            pix_cnt_q    <= pix_cnt_d;
            act_cnt_q    <= act_cnt_d;
            hsw_cnt_q    <= hsw_cnt_d;
            line_total_q <= line_total_d;
            line_hsw_q   <= line_hsw_d;
            frame_hact_q <= frame_hact_d;
            vact_cnt_q   <= vact_cnt_d;
            line_cnt_q   <= line_cnt_d;
            vsw_cnt_q    <= vsw_cnt_d;
            h_total_q    <= h_total_d;
            h_active_q   <= h_active_d;
            h_sync_w_q   <= h_sync_w_d;
            v_total_q    <= v_total_d;
            v_active_q   <= v_active_d;
            v_sync_w_q   <= v_sync_w_d;
            frame_stb_q  <= frame_stb_d;
        end
    end

    assign h_total   = h_total_q;
    assign h_active  = h_active_q;
    assign h_sync_w  = h_sync_w_q;
    assign v_total   = v_total_q;
    assign v_active  = v_active_q;
    assign v_sync_w  = v_sync_w_q;
    assign frame_stb = frame_stb_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: doc/video_timing_meter.md
# video_timing_meter

Passive receiver for the suite's video output. It sits beside `suite` in `emu`, observes the same `ce_pix`/sync/blank stream that drives `VGA_*`, and measures the raster geometry frame by frame. Measured totals are exported for on-screen display and self-check: horizontal total, active and sync width in pixels; vertical total, active and sync width in lines. A lock flag reports when two consecutive frames measure identically.

## Interface
Parameters:
- `HW`, default 12: width of horizontal counters and outputs (pixels).
- `VW`, default 11: width of vertical counters and outputs (lines).
- `H_TIMEOUT`, default 4095: pixel count without an `h_sync` rise before the meter falls back to SEARCH.

Ports:
- `clk`  in  1  system clock (`clk_sys`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce_pix`  in  1  pixel enable; all sampling happens only on cycles with `ce_pix`=1.
- `h_sync`  in  1  horizontal sync, active-high.
- `v_sync`  in  1  vertical sync, active-high.
- `h_blank`  in  1  horizontal blank, active-high.
- `v_blank`  in  1  vertical blank, active-high.
- `h_total`  out  HW  pixels per line.
- `h_active`  out  HW  maximum count of non-blank pixels in any line of the frame.
- `h_sync_w`  out  HW  `h_sync` high pixels in the last complete line.
- `v_total`  out  VW  lines per frame.
- `v_active`  out  VW  lines containing at least one non-blank pixel.
- `v_sync_w`  out  VW  lines whose `h_sync` rise saw `v_sync`=1.
- `frame_stb`  out  1  one-clk pulse when outputs update.
- `locked`  out  1  last two latched frames are identical.

## Operation
- Edge detection: registers `hs_q`/`vs_q` update only on `ce_pix`. A rise is a `ce_pix` cycle with input=1 and `_q`=0.
- Horizontal counting runs on `ce_pix` cycles:
  - `pix_cnt` resets to 1 on an `h_sync` rise and otherwise increments.
  - `act_cnt` counts pixels with `~h_blank & ~v_blank`.
  - `hsw_cnt` counts pixels with `h_sync`=1.
  - On each `h_sync` rise, the finished line is committed: `line_total` <= `pix_cnt`, `line_hsw` <= `hsw_cnt`, `frame_hact` <= max(`frame_hact`, `act_cnt`). A line with `act_cnt`≠0 increments `vact_cnt`. The line counters then restart, with the current pixel counted as pixel 0 of the new line.
- Vertical counting: `line_cnt` increments on each `h_sync` rise. `vsw_cnt` increments on an `h_sync` rise when `v_sync`=1.
- Coincident `h_sync` and `v_sync` rise: the line commit happens first. The new line then belongs to the new frame, so `v_total` excludes it and the new frame's `line_cnt` starts at 1.
- All counters saturate at all-ones and never wrap.
- FSM (2-bit):
  - SEARCH: outputs hold. On a `v_sync` rise, clear frame accumulators and go to MEASURE.
  - MEASURE: accumulate. On a `v_sync` rise, latch outputs, pulse `frame_stb`, clear frame accumulators, and go to LOCKED if the latched values equal the previous latched values; otherwise stay in MEASURE.
  - LOCKED: same as MEASURE. Any mismatch returns the FSM to MEASURE.
  - From any state: if `pix_cnt` reaches `H_TIMEOUT` without an `h_sync` rise, go to SEARCH.
- `locked` = (state==LOCKED).
- Reset: all outputs 0, `locked`=0, state SEARCH, edge registers 0. Reset mid-frame discards the partial measurement; the first `v_sync` rise after reset only arms the meter.

## Timing
- Outputs and `frame_stb` are registered. They change on the clk edge following the `ce_pix` cycle that sampled the `v_sync` rise, giving 1 clk of latency from the sampling cycle.
- `frame_stb` is exactly one `clk` wide, even if `ce_pix` is continuously high.
- `locked` changes in the same cycle as `frame_stb`, or in the cycle after the timeout is detected.
- Inputs are sampled only when `ce_pix`=1. Input changes between enables are ignored.
- First valid outputs appear at the second `v_sync` rise after reset. The earliest `locked`=1 is at the third.

## Test plan
- Synthetic raster with `ce_pix`=1 every clk: 16-pixel lines, `h_sync` high pixels 0–1, `h_blank` high pixels 10–15, 12-line frames, `v_sync` high lines 0–2, `v_blank` high lines 8–11. Required: `h_total`=16, `h_active`=10, `h_sync_w`=2, `v_total`=12, `v_active`=8, `v_sync_w`=3. `frame_stb` pulses on the 2nd `v_sync` rise. `locked`=1 from the 3rd rise.
- Same raster with `ce_pix` asserted every 4th clk. Required: identical values, and `frame_stb` stays 1 clk wide.
- After lock, switch to 13-line frames. Required: `v_total`=13 and `locked`=0 at the next strobe; `locked`=1 again one frame later.
- Stop `h_sync` for 4096 pixels. Required: `locked`=0 and no further `frame_stb`. The outputs hold their last values until two new `v_sync` rises.
- Assert `reset_n`=0 mid-frame for 3 clk. Required: all outputs read 0 immediately, asynchronously. The first strobe after release occurs on the second `v_sync` rise.
- Raster with `v_sync` rise coincident with `h_sync` rise. Required: `v_total`=12, not 13 and not 11.
